// File: rtl/dbus_mmio_if.sv
// Core data-port bundle between the core and dbus_mmio.
// master = core side, slave = dbus_mmio side.
interface dbus_mmio_if;
  logic [15:0] dat_a;
  logic [3:0]  dat_we;
  logic [31:0] dat_wd;
  logic [3:0]  dat_re;
  logic [31:0] dat_rd;

  modport master (
    output dat_a,
    output dat_we,
    output dat_wd,
    output dat_re,
    input  dat_rd
  );

  modport slave (
    input  dat_a,
    input  dat_we,
    input  dat_wd,
    input  dat_re,
    output dat_rd
  );
endinterface

// File: rtl/dbus_mmio.sv
// Data-bus splitter: SRAM pass-through plus MMIO timer/GPIO/TX FIFO.
// Ports: clk, rst, bus (core data port), sram_*, gpio_o/i, timer_irq, tx_*.
module dbus_mmio #(
  parameter int TICK_DIV = 1,
  parameter int TX_DEPTH = 4,
  parameter int GPIO_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  dbus_mmio_if.slave        bus,
  output logic [15:0]       sram_a,
  output logic [3:0]        sram_we,
  output logic [31:0]       sram_wd,
  output logic [3:0]        sram_re,
  input  logic [31:0]       sram_rd,
  output logic [GPIO_W-1:0] gpio_o,
  input  logic [GPIO_W-1:0] gpio_i,
  output logic              timer_irq,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = $clog2(TX_DEPTH);
  localparam int CW = AW + 1;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  we
  );
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = we[i] ? wd[8*i +: 8] : old[8*i +: 8];
    end
    return res;
  endfunction

  logic              w_mmio;
  logic [2:0]        w_idx;
  logic [7:0]        w_sel;
  logic              w_wr;
  logic              w_rd;
  logic [31:0]       w_rdata;
  logic [31:0]       w_status;
  logic [31:0]       w_mtime_m;
  logic [31:0]       w_cmp_m;
  logic [GPIO_W-1:0] w_gpio_m;
  logic              w_tick;
  logic              w_pop;
  logic              w_push_req;
  logic              w_push;
  logic              w_full;
  logic              w_ovf_set;
  logic              w_ovf_clr;
  logic [31:0]       w_live;

  logic [PW-1:0]     r_presc;
  logic [31:0]       r_mtime;
  logic [31:0]       r_mtimecmp;
  logic              r_irq;
  logic [GPIO_W-1:0] r_gpio_o;
  logic [GPIO_W-1:0] r_sync1;
  logic [GPIO_W-1:0] r_sync2;
  logic [7:0]        r_mem [TX_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_ovf;
  logic              r_pend;
  logic              r_is_mmio;
  logic [31:0]       r_mmio_q;
  logic [31:0]       r_hold;

  assign w_mmio = bus.dat_a[15];
  assign w_idx  = bus.dat_a[2:0];
  assign w_sel  = 8'b1 << w_idx;
  assign w_wr   = w_mmio & (|bus.dat_we);
  assign w_rd   = |bus.dat_re;

  assign sram_a  = bus.dat_a;
  assign sram_wd = bus.dat_wd;
  assign sram_we = w_mmio ? 4'b0 : bus.dat_we;
  assign sram_re = w_mmio ? 4'b0 : bus.dat_re;

  assign w_mtime_m = merge(r_mtime, bus.dat_wd, bus.dat_we);
  assign w_cmp_m   = merge(r_mtimecmp, bus.dat_wd, bus.dat_we);

  always_comb begin
    w_gpio_m = r_gpio_o;
    for (int i = 0; i < GPIO_W; i++) begin
      if (bus.dat_we[i/8]) w_gpio_m[i] = bus.dat_wd[i];
    end
  end

  assign w_tick = (r_presc == PW'(TICK_DIV - 1));

  assign tx_valid   = (r_count != '0);
  assign tx_data    = r_mem[r_rd_ptr];
  assign w_full     = (r_count == CW'(TX_DEPTH));
  assign w_pop      = tx_valid & tx_ready;
  assign w_push_req = w_wr & w_sel[4] & bus.dat_we[0];
  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_ovf_set  = w_push_req & ~w_push;
  assign w_ovf_clr  = w_wr & w_sel[5] & bus.dat_we[0] & bus.dat_wd[3];

  assign w_status = {24'b0, 4'(r_count), r_ovf,
                     w_full, ~tx_valid, r_irq};

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      w_sel[0]: w_rdata = r_mtime;
      w_sel[1]: w_rdata = r_mtimecmp;
      w_sel[2]: w_rdata = 32'(r_gpio_o);
      w_sel[3]: w_rdata = 32'(r_sync2);
      w_sel[5]: w_rdata = w_status;
      default:  w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc    <= '0;
      r_mtime    <= '0;
      r_mtimecmp <= 32'hFFFF_FFFF;
      r_irq      <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      // Software write wins over the tick; prescaler keeps running.
      if (w_wr && w_sel[0]) r_mtime <= w_mtime_m;
      else if (w_tick)      r_mtime <= r_mtime + 32'd1;
      if (w_wr && w_sel[1]) r_mtimecmp <= w_cmp_m;
      r_irq <= (r_mtime >= r_mtimecmp);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gpio_o <= '0;
      r_sync1  <= '0;
      r_sync2  <= '0;
    end else begin
      if (w_wr && w_sel[2]) r_gpio_o <= w_gpio_m;
      r_sync1 <= gpio_i;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TX_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= bus.dat_wd[7:0];
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign w_live     = r_is_mmio ? r_mmio_q : sram_rd;
  assign bus.dat_rd = r_pend ? w_live : r_hold;

  // r_hold keeps the last returned word so dat_rd is stable when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend    <= 1'b0;
      r_is_mmio <= 1'b0;
      r_mmio_q  <= '0;
      r_hold    <= '0;
    end else begin
      r_pend <= w_rd;
      if (w_rd) begin
        r_is_mmio <= w_mmio;
        if (w_mmio) r_mmio_q <= w_rdata;
      end
      if (r_pend) r_hold <= w_live;
    end
  end

  assign gpio_o    = r_gpio_o;
  assign timer_irq = r_irq;

endmodule

// File: tb/tb_dbus_mmio.sv
// Self-checking bench for dbus_mmio.
// Read data and TX bytes are checked against scoreboard queues.
module tb_dbus_mmio;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sram_a;
  logic [3:0]  sram_we;
  logic [31:0] sram_wd;
  logic [3:0]  sram_re;
  logic [31:0] sram_rd = '0;
  logic [7:0]  gpio_o;
  logic [7:0]  gpio_i = '0;
  logic        timer_irq;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;

  dbus_mmio_if bus ();

  dbus_mmio #(.TICK_DIV(1), .TX_DEPTH(4), .GPIO_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .sram_a    (sram_a),
    .sram_we   (sram_we),
    .sram_wd   (sram_wd),
    .sram_re   (sram_re),
    .sram_rd   (sram_rd),
    .gpio_o    (gpio_o),
    .gpio_i    (gpio_i),
    .timer_irq (timer_irq),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] rd_q [$];
  logic [7:0]  tx_q [$];
  bit rd_pend = 1'b0;
  bit m_ovf = 1'b0;

  initial begin
    bus.dat_a  = '0;
    bus.dat_we = '0;
    bus.dat_wd = '0;
    bus.dat_re = '0;
  end

  // Inputs change at posedge+2; monitors sample at negedge.
  always @(negedge clk) begin
    logic [31:0] e;
    logic [7:0]  b;
    if (rd_pend) begin
      n_checks++;
      if (rd_q.size() == 0) begin
        n_errors++;
        $display("FAIL rd_sb: dat_rd=%h, no read expected",
                 bus.dat_rd);
      end else begin
        e = rd_q.pop_front();
        if (bus.dat_rd !== e) begin
          n_errors++;
          $display("FAIL rd_sb: dat_rd=%h expected %h",
                   bus.dat_rd, e);
        end
      end
    end
    rd_pend = (bus.dat_re != 4'b0);
    if (tx_valid === 1'b1 && tx_ready && !rst) begin
      n_checks++;
      if (tx_q.size() == 0) begin
        n_errors++;
        $display("FAIL tx_sb: tx_data=%h, no byte expected",
                 tx_data);
      end else begin
        b = tx_q.pop_front();
        if (tx_data !== b) begin
          n_errors++;
          $display("FAIL tx_sb: tx_data=%h expected %h",
                   tx_data, b);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t limit 200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
    bus.dat_we = '0;
    bus.dat_re = '0;
  endtask

  task automatic issue_wr(input logic [2:0] idx,
                          input logic [3:0] we,
                          input logic [31:0] wd);
    bus.dat_a  = {13'h1000, idx};
    bus.dat_we = we;
    bus.dat_wd = wd;
  endtask

  task automatic issue_rd(input logic [15:0] a,
                          input logic [31:0] exp);
    bus.dat_a  = a;
    bus.dat_re = 4'hF;
    rd_q.push_back(exp);
  endtask

  task automatic push_byte(input logic [7:0] b);
    bit pop;
    pop = (tx_q.size() != 0) && tx_ready;
    if (tx_q.size() < 4 || pop) tx_q.push_back(b);
    else m_ovf = 1'b1;
    issue_wr(3'd4, 4'b0001, {24'h0, b});
  endtask

  function automatic logic [31:0] st(input int cnt,
                                     input bit ovf,
                                     input bit irq);
    logic [31:0] v;
    v = '0;
    v[0] = irq;
    v[1] = (cnt == 0);
    v[2] = (cnt == 4);
    v[3] = ovf;
    v[7:4] = 4'(cnt);
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_checks++;
    if (bus.dat_rd !== 32'h0 || tx_valid !== 1'b0 ||
        tx_data !== 8'h0 || timer_irq !== 1'b0 ||
        gpio_o !== 8'h0) begin
      n_errors++;
      $display("FAIL reset: rd=%h v=%b d=%h irq=%b g=%h expected 0",
               bus.dat_rd, tx_valid, tx_data, timer_irq, gpio_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    sram_rd = 32'hDEAD_BEEF;
    gpio_i  = 8'hA5;
    repeat (3) step();
    issue_rd(16'h0010, 32'hDEAD_BEEF);
    #1;
    n_checks++;
    if (sram_re !== 4'hF || sram_a !== 16'h0010) begin
      n_errors++;
      $display("FAIL sram_pass: re=%h a=%h expected f 0010",
               sram_re, sram_a);
    end
    step();
    issue_rd(16'h8003, 32'h0000_00A5);
    #1;
    n_checks++;
    if (sram_re !== 4'h0) begin
      n_errors++;
      $display("FAIL sram_re_gate: re=%h expected 0", sram_re);
    end
    step();
    issue_wr(3'd6, 4'hF, 32'h1234_5678);
    #1;
    n_checks++;
    if (sram_we !== 4'h0) begin
      n_errors++;
      $display("FAIL sram_we_gate: we=%h expected 0", sram_we);
    end
    step();
    sram_rd = 32'h1111_1111;
    step();
    n_checks++;
    if (bus.dat_rd !== 32'h0000_00A5) begin
      n_errors++;
      $display("FAIL rd_hold: dat_rd=%h expected 000000a5",
               bus.dat_rd);
    end
    issue_rd(16'h8006, 32'h0);
    step();
    issue_rd(16'h8004, 32'h0);
    step();
  endtask

  task automatic test_timer();
    issue_wr(3'd1, 4'hF, 32'd20);
    step();
    issue_wr(3'd0, 4'hF, 32'd0);
    step();
    repeat (20) step();
    n_checks++;
    if (timer_irq !== 1'b0) begin
      n_errors++;
      $display("FAIL irq_early: irq=%b expected 0", timer_irq);
    end
    step();
    n_checks++;
    if (timer_irq !== 1'b1) begin
      n_errors++;
      $display("FAIL irq_rise: irq=%b expected 1", timer_irq);
    end
    issue_wr(3'd0, 4'hF, 32'hFFFF_FFFF);
    step();
    issue_rd(16'h8000, 32'hFFFF_FFFF);
    step();
    issue_rd(16'h8000, 32'h0);
    step();
    issue_wr(3'd0, 4'hF, 32'h1234_5600);
    step();
    issue_wr(3'd0, 4'b0001, 32'h0000_0012);
    step();
    issue_rd(16'h8000, 32'h1234_5612);
    step();
    issue_wr(3'd1, 4'hF, 32'hFFFF_FFFF);
    issue_rd(16'h8001, 32'd20);
    step();
    issue_rd(16'h8001, 32'hFFFF_FFFF);
    step();
    step();
    n_checks++;
    if (timer_irq !== 1'b0) begin
      n_errors++;
      $display("FAIL irq_fall: irq=%b expected 0", timer_irq);
    end
  endtask

  task automatic test_fifo_ovf();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_byte(8'h41 + 8'(i));
      step();
    end
    issue_rd(16'h8005, st(tx_q.size(), m_ovf, 1'b0));
    step();
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
      n_errors++;
      $display("FAIL fifo_head: v=%b d=%h expected 1 41",
               tx_valid, tx_data);
    end
    issue_wr(3'd5, 4'b0001, 32'h8);
    m_ovf = 1'b0;
    step();
    issue_rd(16'h8005, st(tx_q.size(), m_ovf, 1'b0));
    step();
  endtask

  task automatic test_fifo_push_pop();
    tx_ready = 1'b1;
    push_byte(8'h46);
    step();
    tx_ready = 1'b0;
    issue_rd(16'h8005, st(tx_q.size(), m_ovf, 1'b0));
    step();
    n_checks++;
    if (tx_data !== 8'h42) begin
      n_errors++;
      $display("FAIL fifo_pp_head: d=%h expected 42", tx_data);
    end
    tx_ready = 1'b1;
    repeat (6) step();
    tx_ready = 1'b0;
    n_checks++;
    if (tx_q.size() != 0 || tx_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL fifo_drain: left=%0d v=%b expected 0 0",
               tx_q.size(), tx_valid);
    end
  endtask

  task automatic test_gpio();
    issue_wr(3'd2, 4'b0010, 32'h0000_FF00);
    step();
    n_checks++;
    if (gpio_o !== 8'h00) begin
      n_errors++;
      $display("FAIL gpio_lane1: gpio_o=%h expected 00", gpio_o);
    end
    issue_wr(3'd2, 4'b0001, 32'h0000_003C);
    step();
    n_checks++;
    if (gpio_o !== 8'h3C) begin
      n_errors++;
      $display("FAIL gpio_lane0: gpio_o=%h expected 3c", gpio_o);
    end
    issue_rd(16'h8002, 32'h3C);
    step();
    issue_rd(16'h80FA, 32'h3C);
    step();
  endtask

  task automatic test_reset_mid();
    tx_ready = 1'b0;
    push_byte(8'h50);
    step();
    push_byte(8'h51);
    step();
    issue_wr(3'd1, 4'hF, 32'h0);
    step();
    step();
    n_checks++;
    if (timer_irq !== 1'b1 || tx_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL pre_rst: irq=%b v=%b expected 1 1",
               timer_irq, tx_valid);
    end
    issue_rd(16'h8002, 32'h3C);
    step();
    rst = 1'b1;
    issue_rd(16'h8001, 32'h0);
    step();
    rst = 1'b0;
    tx_q.delete();
    m_ovf = 1'b0;
    n_checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h0 ||
        timer_irq !== 1'b0 || gpio_o !== 8'h0) begin
      n_errors++;
      $display("FAIL mid_rst: v=%b d=%h irq=%b g=%h expected 0",
               tx_valid, tx_data, timer_irq, gpio_o);
    end
    issue_rd(16'h8001, 32'hFFFF_FFFF);
    step();
    issue_rd(16'h8005, st(0, 1'b0, 1'b0));
    step();
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_timer();
    test_fifo_ovf();
    test_fifo_push_pop();
    test_gpio();
    test_reset_mid();
    n_checks++;
    if (rd_q.size() != 0) begin
      n_errors++;
      $display("FAIL rd_left: %0d reads unanswered, expected 0",
               rd_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dbus_mmio.md
Name: dbus_mmio

Overview:
- Sits directly downstream of the core data port (dat_a/dat_we/dat_wd/dat_re/dat_rd) and splits it between the data SRAM (sram1) and a small MMIO register block.
- The MMIO block holds a 32-bit timer with compare interrupt, GPIO out/in, and a byte-wide debug TX FIFO.
- Both regions return read data exactly one cycle after the request, so the core observes uniform SRAM-like latency.

Parameters:
TICK_DIV, 1, mtime increments once every TICK_DIV cycles (>=1)
TX_DEPTH, 4, TX FIFO entries (power of 2, >=2)
GPIO_W, 8, GPIO output/input width (1..32)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
dat_a  in  16  core word address; bit15=1 selects MMIO
dat_we  in  4  core byte write enables
dat_wd  in  32  core write data
dat_re  in  4  core byte read enables
dat_rd  out  32  read data to core, valid 1 cycle after dat_re!=0
sram_a  out  16  to sram1, equals dat_a
sram_we  out  4  dat_we gated by ~dat_a[15]
sram_wd  out  32  equals dat_wd
sram_re  out  4  dat_re gated by ~dat_a[15]
sram_rd  in  32  sram1 read data (1-cycle latency)
gpio_o  out  GPIO_W  GPIO output register
gpio_i  in  GPIO_W  asynchronous GPIO inputs
timer_irq  out  1  registered, mtime >= mtimecmp (unsigned)
tx_valid  out  1  TX FIFO head valid
tx_data  out  8  TX FIFO head byte
tx_ready  in  1  consumer accepts head when tx_valid&tx_ready

Behaviour:
- Decode is combinational; the SRAM path has zero added latency. MMIO strobes never reach sram1.
- MMIO register index = dat_a[2:0]; dat_a[14:3] ignored (aliases).
  - 0 MTIME: RW.
  - 1 MTIMECMP: RW, reset 0xFFFF_FFFF.
  - 2 GPIO_OUT: RW, bits above GPIO_W read 0.
  - 3 GPIO_IN: RO, 2-flop synchronised.
  - 4 TX_DATA: WO, reads 0.
  - 5 STATUS: bit0 timer_irq, bit1 fifo_empty, bit2 fifo_full, bit3 ovf (W1C via dat_we[0]&dat_wd[3]), bits[7:4] fifo count, rest 0.
  - 6, 7: read 0, writes ignored.
- RW writes merge per byte lane under dat_we.
- Read path: a read-select flag (is_mmio) is registered when dat_re!=0. dat_rd = is_mmio ? mmio_rdata_q : sram_rd.
  - mmio_rdata_q captures the full 32-bit register value (dat_re lanes do not mask it).
  - When no read is pending, dat_rd holds its last value.
- Timer:
  - A prescaler counts 0..TICK_DIV-1; mtime += 1 (wraps 0xFFFF_FFFF→0) on the terminal count.
  - An MTIME write in the same cycle wins: merged value is stored, no increment that cycle, prescaler not reset.
  - timer_irq updates every cycle from the current mtime/mtimecmp registers, i.e. it lags a register change by 1 cycle.
- TX FIFO:
  - Push when MMIO write to index 4 with dat_we[0]; byte = dat_wd[7:0].
  - Pop when tx_valid&tx_ready.
  - Push is accepted if count<TX_DEPTH or a pop occurs the same cycle.
  - Otherwise the push is dropped and ovf is set (sticky).
  - Simultaneous push+pop on empty: no pop (tx_valid=0); push accepted.
  - tx_data is stable while tx_valid&~tx_ready. Pointers wrap modulo TX_DEPTH.
- Simultaneous read and write to the same MMIO register: the read returns the pre-write value.
- Reset (any cycle, including mid-read) values:
  - dat_rd=0, is_mmio=0, mtime=0, prescaler=0, mtimecmp=0xFFFF_FFFF, gpio_o=0, sync flops=0.
  - FIFO empty, ovf=0, timer_irq=0, tx_valid=0, tx_data=0.
  - A read issued in the reset cycle returns 0.

Test Plan:
- Read SRAM 0x0010 (sram_rd=0xDEADBEEF) then MMIO read index 3 back-to-back with gpio_i=0xA5 held 3 cycles -> dat_rd=0xDEADBEEF then 0x000000A5 on consecutive cycles; sram_re=0 during the MMIO access.
- TICK_DIV=1: write MTIMECMP=20 at t0, MTIME=0 -> timer_irq rises 21–22 cycles later; write MTIME=0xFFFF_FFFF -> next cycle reads 0 (wrap); write only dat_we=4'b0001 0x12 to MTIME=0x1234_5600 -> value 0x1234_5612, no increment that cycle.
- Push 5 bytes 0x41..0x45 with tx_ready=0 (TX_DEPTH=4) -> count=4, full=1, ovf=1, 0x45 lost; then write STATUS 0x8 -> ovf=0.
- Full FIFO, tx_ready=1 and push 0x46 same cycle -> 0x41 popped, 0x46 accepted, ovf unchanged, drain order 0x42,0x43,0x44,0x46.
- Byte-lane write GPIO_OUT dat_we=4'b0010 wd=0x0000FF00 with GPIO_W=8 -> gpio_o unchanged 0x00; dat_we=0001 wd=0x3C -> gpio_o=0x3C.
- Assert rst while an MMIO read is pending and FIFO holds 2 bytes -> next cycle dat_rd=0, tx_valid=0, mtimecmp reads 0xFFFF_FFFF, timer_irq=0.
